// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader
// Read-side master for a dual-port RAM with a registered read port. Given a
// start address and a word count it issues sequential reads (wrapping at the
// top of the address space) and streams the returned words out on a
// valid/ready interface. At most 4 words are ever buffered or in flight.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, start_addr,  burst request (honoured only when busy=0)
//   length
//   busy, done          burst in progress / one-cycle completion pulse
//   ram_rd_en,          RAM read port request (registered)
//   ram_rd_addr
//   ram_dout            RAM read data, valid one cycle after rd_en is sampled
//   m_valid, m_data,    output stream
//   m_ready
module dpram_burst_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_W:0] LenOne = 1;
    localparam int unsigned TailDepth = 3;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
    logic [ADDR_W:0]     pop_cnt_q, pop_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    // pipe_q[0]: read request on the RAM port this cycle (drives ram_rd_en)
    // pipe_q[1]: RAM has sampled our request, ram_dout holds our word
    logic [1:0]          pipe_q, pipe_d;
    logic [DATA_W-1:0]   head_q, head_d;
    logic                head_vld_q, head_vld_d;
    logic [DATA_W-1:0]   tail_q [TailDepth];
    logic [DATA_W-1:0]   tail_d [TailDepth];
    logic [1:0]          tail_cnt_q, tail_cnt_d;

    logic                pop;
    logic                cap;
    logic                load;
    logic                issue;
    logic                credit_ok;
    logic [2:0]          occ;
    logic [3:0]          credit_sum;
    logic                tail_wr;
    logic [1:0]          tail_wr_idx;

    assign pop = head_vld_q & m_ready;
    assign cap = pipe_q[1];

    // Words held plus reads in flight, plus the read we would issue now,
    // must fit in 4 slots once this edge's pop is accounted for.
    assign occ        = {2'b00, head_vld_q} + {1'b0, tail_cnt_q};
    assign credit_sum = {1'b0, occ} + {3'b000, pipe_q[0]} + {3'b000, pipe_q[1]} + 4'd1;
    assign credit_ok  = credit_sum <= (4'd4 + {3'b000, pop});

    // Control FSM, address generation and counters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        issue_cnt_d = issue_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        if (pop) begin
            pop_cnt_d = pop_cnt_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        // First read goes out immediately; FIFO and pipe are empty here.
                        issue       = 1'b1;
                        rd_addr_d   = start_addr;
                        addr_d      = start_addr + 1'b1;
                        issue_cnt_d = length - 1'b1;
                        pop_cnt_d   = length;
                        busy_d      = 1'b1;
                        state_d     = (length == LenOne) ? StDrain : StRun;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    rd_addr_d   = addr_q;
                    addr_d      = addr_q + 1'b1;
                    issue_cnt_d = issue_cnt_q - 1'b1;
                    if (issue_cnt_q == LenOne) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && (pop_cnt_q == LenOne)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pipe_d = {pipe_q[0], issue};
    end

    // Output buffer: registered head plus a 3-deep shift queue behind it.
    always_comb begin
        head_d      = head_q;
        head_vld_d  = head_vld_q;
        tail_d      = tail_q;
        tail_cnt_d  = tail_cnt_q;
        tail_wr     = 1'b0;
        tail_wr_idx = tail_cnt_q;
        load        = !head_vld_q || pop;

        if (load) begin
            if (tail_cnt_q != 2'd0) begin
                head_d     = tail_q[0];
                head_vld_d = 1'b1;
                tail_d[0]  = tail_q[1];
                tail_d[1]  = tail_q[2];
                if (cap) begin
                    tail_wr     = 1'b1;
                    tail_wr_idx = tail_cnt_q - 1'b1;
                end else begin
                    tail_cnt_d = tail_cnt_q - 1'b1;
                end
            end else if (cap) begin
                head_d     = ram_dout;
                head_vld_d = 1'b1;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (cap) begin
            tail_wr     = 1'b1;
            tail_wr_idx = tail_cnt_q;
            tail_cnt_d  = tail_cnt_q + 1'b1;
        end

        for (int i = 0; i < TailDepth; i++) begin
            if (tail_wr && (tail_wr_idx == 2'(i))) begin
                tail_d[i] = ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pipe_q      <= 2'b00;
            head_q      <= '0;
            head_vld_q  <= 1'b0;
            tail_cnt_q  <= 2'd0;
            for (int i = 0; i < TailDepth; i++) begin
                tail_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            issue_cnt_q <= issue_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pipe_q      <= pipe_d;
            head_q      <= head_d;
            head_vld_q  <= head_vld_d;
            tail_cnt_q  <= tail_cnt_d;
            for (int i = 0; i < TailDepth; i++) begin
                tail_q[i] <= tail_d[i];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_rd_en   = pipe_q[0];
    assign ram_rd_addr = rd_addr_q;
    assign m_valid     = head_vld_q;
    assign m_data      = head_q;

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Scoreboard bench for dpram_burst_reader with a behavioural 16x8 RAM
// (registered read) preloaded with RAM[i] = 3*i.
module tb_dpram_burst_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, ram_rd_en;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_dout;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready = 1'b1;

    dpram_burst_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_dout   (ram_dout),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [16];
    always_ff @(posedge clk) begin
        if (ram_rd_en) ram_dout <= mem[ram_rd_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0d expected nothing", name, act);
    endtask

    // Scoreboard state
    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    logic [AW-1:0] exp_addr [$];
    int            done_cnt = 0;
    int            issued = 0;
    int            accepted = 0;
    logic          expect_done = 1'b0;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_data = '0;
    logic          mon_en = 1'b0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (expect_done) begin
                check("done_after_last", {31'd0, done}, 1);
                check("busy_low_at_done", {31'd0, busy}, 0);
                expect_done = 1'b0;
            end
            if (stalled) begin
                check("stall_valid", {31'd0, m_valid}, 1);
                check("stall_data", {24'd0, m_data}, {24'd0, stall_data});
            end
            if (ram_rd_en) begin
                issued++;
                if (exp_addr.size() == 0) flag_fail("unexpected_read", {28'd0, ram_rd_addr});
                else check("rd_addr", {28'd0, ram_rd_addr}, {28'd0, exp_addr.pop_front()});
            end
            check("inflight_le4", issued - accepted, ((issued - accepted) <= 4) ?
                  issued - accepted : 4);
            if (m_valid && m_ready) begin
                accepted++;
                if (exp_data.size() == 0) begin
                    flag_fail("unexpected_word", {24'd0, m_data});
                end else begin
                    check("m_data", {24'd0, m_data}, {24'd0, exp_data.pop_front()});
                    if (exp_last.pop_front()) expect_done = 1'b1;
                end
            end
            stalled    = m_valid && !m_ready;
            stall_data = m_data;
        end
    end

    // m_ready driver: constant 1, or the 1,0,0,1,0 pattern.
    logic toggle_mode = 1'b0;
    initial begin
        logic [4:0] pat;
        int pidx;
        pat  = 5'b01001; // bit i = cycle i of the pattern
        pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) begin
                m_ready = pat[pidx];
                pidx    = (pidx + 1) % 5;
            end else begin
                m_ready = 1'b1;
                pidx    = 0;
            end
        end
    end

    task automatic expect_burst(input int a, input int l);
        for (int i = 0; i < l; i++) begin
            logic [AW-1:0] ad;
            ad = AW'((a + i) % 16);
            exp_addr.push_back(ad);
            exp_data.push_back(mem[ad]);
            exp_last.push_back(i == l - 1);
        end
    endtask

    // Returns at 1 ns after the edge that samples start (edge N).
    task automatic pulse_start(input int a, input int l);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(a);
        length     = (AW + 1)'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int exp_done, output int done_at);
        int k;
        done_at = -1;
        k = 0;
        while (k < 300 && !(exp_data.size() == 0 && !busy && !done)) begin
            @(posedge clk);
            #1;
            k++;
            if (done && done_at < 0) done_at = k;
        end
        if (k >= 300) flag_fail({name, "_timeout"}, k);
        check({name, "_words_left"}, exp_data.size(), 0);
        check({name, "_done_count"}, done_cnt, exp_done);
        done_cnt = 0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, {31'd0, busy}, 0);
        check({name, "_done"}, {31'd0, done}, 0);
        check({name, "_rd_en"}, {31'd0, ram_rd_en}, 0);
        check({name, "_rd_addr"}, {28'd0, ram_rd_addr}, 0);
        check({name, "_m_valid"}, {31'd0, m_valid}, 0);
        check({name, "_m_data"}, {24'd0, m_data}, 0);
    endtask

    initial begin
        int dat;
        for (int i = 0; i < 16; i++) mem[i] = DW'(3 * i);

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // 16-word burst from 0 with m_ready=1: latency and throughput
        expect_burst(0, 16);
        pulse_start(0, 16);
        check("t1_rd_en_N", {31'd0, ram_rd_en}, 1);
        check("t1_rd_addr_N", {28'd0, ram_rd_addr}, 0);
        check("t1_busy_N", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        check("t1_valid_N1", {31'd0, m_valid}, 0);
        @(posedge clk);
        #1;
        check("t1_valid_N2", {31'd0, m_valid}, 1);
        check("t1_data_N2", {24'd0, m_data}, 0);
        wait_idle("t1", 1, dat);
        // last word accepted on edge N+18, done raised on that same edge
        check("t1_done_cycle", dat, 16);

        // Wrap-around burst
        expect_burst(14, 4);
        pulse_start(14, 4);
        wait_idle("t2", 1, dat);

        // Backpressure pattern 1,0,0,1,0
        toggle_mode = 1'b1;
        expect_burst(3, 16);
        pulse_start(3, 16);
        wait_idle("t3", 1, dat);
        toggle_mode = 1'b0;

        // Zero-length request
        pulse_start(3, 0);
        check("t4_done_N", {31'd0, done}, 1);
        check("t4_busy_N", {31'd0, busy}, 0);
        check("t4_rd_en_N", {31'd0, ram_rd_en}, 0);
        @(posedge clk);
        #1;
        check("t4_done_N1", {31'd0, done}, 0);
        check("t4_valid_N1", {31'd0, m_valid}, 0);
        wait_idle("t4", 1, dat);

        // Second start while busy is ignored
        expect_burst(5, 16);
        pulse_start(5, 16);
        repeat (2) @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 4'd9;
        length     = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("t5", 1, dat);

        // Reset mid-burst, then a short burst from 7
        expect_burst(0, 16);
        pulse_start(0, 16);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("t6_midreset");
        exp_data.delete();
        exp_last.delete();
        exp_addr.delete();
        expect_done = 1'b0;
        stalled     = 1'b0;
        issued      = 0;
        accepted    = 0;
        done_cnt    = 0;
        rst_n       = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_no_done_after_reset", done_cnt, 0);
        check("t6_idle_after_reset", {31'd0, busy}, 0);
        expect_burst(7, 2);
        pulse_start(7, 2);
        wait_idle("t6", 1, dat);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
